// File: rtl/serial_loader.sv
`default_nettype none
// ============================================================================
// Module      : serial_loader
// Description : Serial-to-parallel front end. Assembles a framed, MSB-first
//               serial bit stream into a Size-bit word, checks a trailing
//               even-parity bit and, on a good frame, presents the word on
//               dout with a single-cycle load_en strobe so it can drive the
//               D/en inputs of a downstream parallel register directly.
//               Bad (parity) or aborted frames pulse frame_err and never
//               disturb dout.
//
// Ports       : clk        - system clock, rising-edge active
//               rstn       - asynchronous reset, active HIGH despite the name
//               start      - frame start request (also aborts a frame)
//               sin        - serial data bit, valid when sin_valid=1
//               sin_valid  - bit strobe, one bit consumed per high cycle
//               dout       - last accepted word, registered and held
//               load_en    - one-cycle strobe when dout is newly valid
//               busy       - high while a frame is in SHIFT or PARITY
//               frame_err  - one-cycle pulse on parity failure or abort
//
// Revision    : 1.0 - initial release
// ============================================================================
module serial_loader #(
    parameter int Size = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            sin,
    input  logic            sin_valid,
    output logic [Size-1:0] dout,
    output logic            load_en,
    output logic            busy,
    output logic            frame_err
);

    localparam int                 c_CNT_W = $clog2(Size + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(Size - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_LOAD   = 2'd3
    } state_t;

    state_t               r_state;
    logic [Size-1:0]      r_sr;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [Size-1:0]      r_dout;
    logic                 r_load_en;
    logic                 r_busy;
    logic                 r_frame_err;

    // Even parity over data + parity bit means the parity bit must equal
    // the XOR reduction of the data bits.
    logic                 w_parity_ok;
    assign w_parity_ok = (sin == ^r_sr);

    // All outputs are registered; each branch below loads the decode that
    // belongs to the state being entered, so busy/load_en line up with
    // r_state on the very same cycle.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state     <= ST_IDLE;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_dout      <= '0;
            r_load_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_load_en   <= 1'b0;
            r_frame_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // A bit strobe coincident with start is deliberately
                    // dropped: the frame begins on the following cycle.
                    if (start) begin
                        r_state <= ST_SHIFT;
                        r_sr    <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (start) begin
                        // Abort: discard the partial word, flag it and
                        // restart as a fresh frame.
                        r_frame_err <= 1'b1;
                        r_sr        <= '0;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                    end else if (sin_valid) begin
                        r_sr  <= {r_sr[Size-2:0], sin};
                        r_cnt <= r_cnt + c_ONE;
                        if (r_cnt == c_LAST) begin
                            r_state <= ST_PARITY;
                        end
                    end
                end

                ST_PARITY: begin
                    if (start) begin
                        r_frame_err <= 1'b1;
                        r_state     <= ST_SHIFT;
                        r_sr        <= '0;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                    end else if (sin_valid) begin
                        r_busy <= 1'b0;
                        if (w_parity_ok) begin
                            r_dout    <= r_sr;
                            r_load_en <= 1'b1;
                            r_state   <= ST_LOAD;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
                end

                ST_LOAD: begin
                    // A start here chains the next frame with no idle gap.
                    if (start) begin
                        r_state <= ST_SHIFT;
                        r_sr    <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dout      = r_dout;
    assign load_en   = r_load_en;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_serial_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_loader
// Description : Scoreboard bench for serial_loader. Stimulus tasks push the
//               expected event (good word or frame error with held dout)
//               into a queue; per-instance monitors pop and compare whenever
//               the DUT raises load_en or frame_err. Covers Size=8 and
//               Size=4 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_loader;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       rstn;
    logic       start8, sin8, sv8;
    logic       start4, sin4, sv4;
    logic [7:0] dout8;
    logic [3:0] dout4;
    logic       load8, busy8, ferr8;
    logic       load4, busy4, ferr4;

    ev_t q8[$];
    ev_t q4[$];
    int  checks;
    int  errors;
    int  loads8;
    int  loads4;

    serial_loader #(.Size(8)) u_dut8 (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start8),
        .sin       (sin8),
        .sin_valid (sv8),
        .dout      (dout8),
        .load_en   (load8),
        .busy      (busy8),
        .frame_err (ferr8)
    );

    serial_loader #(.Size(4)) u_dut4 (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start4),
        .sin       (sin4),
        .sin_valid (sv4),
        .dout      (dout4),
        .load_en   (load4),
        .busy      (busy4),
        .frame_err (ferr4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (load8 || ferr8) begin
            ev_t e;
            if (load8) loads8++;
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ev8_unexpected: load_en=%0b frame_err=%0b dout=%0h with nothing expected", load8, ferr8, dout8);
            end else begin
                e = q8.pop_front();
                chk("ev8_frame_err", {31'd0, ferr8}, {31'd0, e.is_err});
                chk("ev8_load_en",   {31'd0, load8}, {31'd0, ~e.is_err});
                chk("ev8_dout",      {24'd0, dout8}, {24'd0, e.data});
            end
        end
    end

    always @(negedge clk) begin
        if (load4 || ferr4) begin
            ev_t e;
            if (load4) loads4++;
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ev4_unexpected: load_en=%0b frame_err=%0b dout=%0h with nothing expected", load4, ferr4, dout4);
            end else begin
                e = q4.pop_front();
                chk("ev4_frame_err", {31'd0, ferr4}, {31'd0, e.is_err});
                chk("ev4_load_en",   {31'd0, load4}, {31'd0, ~e.is_err});
                chk("ev4_dout",      {28'd0, dout4}, {28'd0, e.data[3:0]});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Inputs are set 1 time unit after an edge and held for one full cycle.
    task automatic cyc8(input logic st, input logic v, input logic b);
        start8 = st; sv8 = v; sin8 = b;
        @(posedge clk); #1;
    endtask

    task automatic cyc4(input logic st, input logic v, input logic b);
        start4 = st; sv4 = v; sin4 = b;
        @(posedge clk); #1;
    endtask

    // Start + 8 data bits (MSB first, optional 1..3 cycle gaps) + parity.
    task automatic frame8(input logic [7:0] d, input logic par, input bit gaps);
        cyc8(1'b1, 1'b0, 1'b0);
        chk("busy8_after_start", {31'd0, busy8}, 32'd1);
        for (int i = 7; i >= 0; i--) begin
            cyc8(1'b0, 1'b1, d[i]);
            if (gaps) begin
                for (int g = 0; g < (i % 3) + 1; g++) begin
                    cyc8(1'b0, 1'b0, 1'b1);
                    chk("busy8_gap", {31'd0, busy8}, 32'd1);
                end
            end
        end
        cyc8(1'b0, 1'b1, par);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- test sequence ----------------
    initial begin
        checks = 0; errors = 0; loads8 = 0; loads4 = 0;
        start8 = 0; sin8 = 0; sv8 = 0;
        start4 = 0; sin4 = 0; sv4 = 0;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b0;

        // Reset state
        chk("rst_dout8",  {24'd0, dout8}, 32'h0);
        chk("rst_load8",  {31'd0, load8}, 32'd0);
        chk("rst_busy8",  {31'd0, busy8}, 32'd0);
        chk("rst_ferr8",  {31'd0, ferr8}, 32'd0);
        chk("rst_dout4",  {28'd0, dout4}, 32'h0);

        // Idle bit strobes are ignored
        cyc8(1'b0, 1'b1, 1'b1);
        cyc8(1'b0, 1'b1, 1'b0);
        chk("idle_busy8", {31'd0, busy8}, 32'd0);

        // Parity error on 0xA5 (parity 1): error, dout stays 00
        q8.push_back('{is_err: 1'b1, data: 8'h00});
        frame8(8'hA5, 1'b1, 1'b0);
        cyc8(1'b0, 1'b0, 1'b0);
        chk("perr_busy8", {31'd0, busy8}, 32'd0);

        // Good frame 0xA5, parity 0
        q8.push_back('{is_err: 1'b0, data: 8'hA5});
        frame8(8'hA5, 1'b0, 1'b0);
        chk("good_busy_in_load", {31'd0, busy8}, 32'd0);
        cyc8(1'b0, 1'b0, 1'b0);
        chk("good_busy_after", {31'd0, busy8}, 32'd0);
        chk("good_dout_held",  {24'd0, dout8}, 32'hA5);

        // Gapped frame 0x3C
        q8.push_back('{is_err: 1'b0, data: 8'h3C});
        frame8(8'h3C, 1'b0, 1'b1);
        cyc8(1'b0, 1'b0, 1'b0);
        chk("gap_dout_held", {24'd0, dout8}, 32'h3C);

        // Abort after 3 bits, then 0xFF
        cyc8(1'b1, 1'b0, 1'b0);
        cyc8(1'b0, 1'b1, 1'b1);
        cyc8(1'b0, 1'b1, 1'b0);
        cyc8(1'b0, 1'b1, 1'b1);
        q8.push_back('{is_err: 1'b1, data: 8'h3C});
        q8.push_back('{is_err: 1'b0, data: 8'hFF});
        cyc8(1'b1, 1'b0, 1'b0);
        chk("abort_ferr_now", {31'd0, ferr8}, 32'd1);
        chk("abort_busy",     {31'd0, busy8}, 32'd1);
        for (int i = 0; i < 8; i++) cyc8(1'b0, 1'b1, 1'b1);
        cyc8(1'b0, 1'b1, 1'b0);
        cyc8(1'b0, 1'b0, 1'b0);
        chk("abort_dout", {24'd0, dout8}, 32'hFF);

        // Reset mid-frame after 5 bits
        cyc8(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc8(1'b0, 1'b1, 1'b1);
        rstn = 1'b1;
        #1;
        chk("midrst_dout8", {24'd0, dout8}, 32'h0);
        chk("midrst_busy8", {31'd0, busy8}, 32'd0);
        chk("midrst_load8", {31'd0, load8}, 32'd0);
        chk("midrst_ferr8", {31'd0, ferr8}, 32'd0);
        start8 = 0; sv8 = 0;
        @(posedge clk); #1;
        rstn = 1'b0;
        cyc8(1'b0, 1'b0, 1'b0);
        q8.push_back('{is_err: 1'b0, data: 8'h81});
        frame8(8'h81, 1'b0, 1'b0);
        cyc8(1'b0, 1'b0, 1'b0);
        chk("post_rst_dout", {24'd0, dout8}, 32'h81);

        // Size=4: 0xB with parity 1, start in LOAD, then 0x6 parity 0
        q4.push_back('{is_err: 1'b0, data: 8'h0B});
        cyc4(1'b1, 1'b0, 1'b0);
        cyc4(1'b0, 1'b1, 1'b1);
        cyc4(1'b0, 1'b1, 1'b0);
        cyc4(1'b0, 1'b1, 1'b1);
        cyc4(1'b0, 1'b1, 1'b1);
        cyc4(1'b0, 1'b1, 1'b1);
        chk("s4_load_now", {31'd0, load4}, 32'd1);
        q4.push_back('{is_err: 1'b0, data: 8'h06});
        cyc4(1'b1, 1'b0, 1'b0);
        chk("s4_b2b_busy", {31'd0, busy4}, 32'd1);
        chk("s4_dout_B",   {28'd0, dout4}, 32'hB);
        cyc4(1'b0, 1'b1, 1'b0);
        cyc4(1'b0, 1'b1, 1'b1);
        cyc4(1'b0, 1'b1, 1'b1);
        cyc4(1'b0, 1'b1, 1'b0);
        cyc4(1'b0, 1'b1, 1'b0);
        cyc4(1'b0, 1'b0, 1'b0);
        cyc4(1'b0, 1'b0, 1'b0);
        chk("s4_dout_6", {28'd0, dout4}, 32'h6);

        // Scoreboard drained and exact strobe counts
        chk("q8_empty", q8.size(), 32'd0);
        chk("q4_empty", q4.size(), 32'd0);
        chk("loads8_total", loads8, 32'd4);
        chk("loads4_total", loads4, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_loader.md
# serial_loader

Serial-to-parallel front end that assembles a framed, MSB-first serial bit stream into a `Size`-bit word. It checks an even-parity bit at the end of each frame. On a good frame it presents the word on `dout` with a one-cycle `load_en` strobe, so it drives the `D`/`en` inputs of the parallel `register` stage directly downstream. Bad or aborted frames never strobe the register.

## Interface
- `Size`, default 8, word width in bits; must match the downstream `register`.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rstn`  input  1  asynchronous reset, active-high; clears all state immediately.
- `start`  input  1  frame start request, sampled on `clk`.
- `sin`  input  1  serial data bit; meaningful only when `sin_valid`=1.
- `sin_valid`  input  1  bit strobe: one bit consumed per cycle in which it is high.
- `dout`  output  `Size`  last accepted word, registered and held; feeds the register's `D`.
- `load_en`  output  1  one-cycle pulse when `dout` is newly valid; feeds the register's `en`.
- `busy`  output  1  high while a frame is in progress (SHIFT or PARITY).
- `frame_err`  output  1  one-cycle pulse on parity failure or aborted frame.

## Operation
- FSM states are IDLE, SHIFT, PARITY and LOAD. There is an internal shift register `sr[Size-1:0]` and a bit counter of width $clog2(Size+1).
- **IDLE**
  - `start`=1 moves to SHIFT and clears `sr` and the counter.
  - `sin_valid` in the same cycle as an accepted `start` is ignored.
  - `sin_valid` while idle is ignored.
- **SHIFT**
  - Each `sin_valid`=1 cycle does `sr <= {sr[Size-2:0], sin}` (MSB first) and increments the counter.
  - When the Size-th bit is taken, the FSM moves to PARITY.
  - A cycle with `sin_valid`=0 holds all state; gaps are unlimited.
- **PARITY**
  - On `sin_valid`=1, compare `sin` with `^sr`. The data bits plus the parity bit must contain an even number of ones.
  - On a match: `dout <= sr`, then go to LOAD.
  - On a mismatch: `frame_err` pulses, `dout` is unchanged, go to IDLE.
- **LOAD**
  - `load_en`=1 for exactly this one cycle.
  - Next state is IDLE, or SHIFT if `start`=1 in this cycle (that start is accepted).
- **Abort:** `start`=1 while in SHIFT or PARITY has three effects:
  - `frame_err` pulses the next cycle.
  - The partial frame is discarded and `dout` is unchanged.
  - The FSM re-enters SHIFT with `sr` and the counter cleared. This is a fresh frame.
- **Simultaneous events:** `start` has priority over `sin_valid` in every state.
- **Output decodes:** `busy` = (state == SHIFT or PARITY). `load_en` = (state == LOAD). `frame_err` is a registered pulse.

## Timing
- **Reset values:** state=IDLE, `sr`=0, counter=0, `dout`=0, `load_en`=0, `busy`=0, `frame_err`=0.
  - Reset asserted mid-frame abandons the frame at once; no `load_en` or `frame_err` is produced.
  - The first `start` after `rstn` deasserts is accepted normally.
- `busy` rises in the cycle after the edge that samples `start`.
- **Latency:** let edge E be the one that samples the parity bit. `dout` updates at E, and `load_en` is high during the cycle that follows E. The downstream register captures `dout` on the next edge.
- **Minimum frame length:** 1 start cycle + `Size` data cycles + 1 parity cycle + 1 LOAD cycle. With a `start` asserted in LOAD, frames run back to back.
- **Bad frame:** `frame_err` is high for the single cycle after the failing parity edge or the aborting `start` edge.
- `dout` is stable whenever `load_en`=1 and between strobes. It never changes without a `load_en`.

## Test plan
- **Good frame:** `Size`=8, `start`, then bits 1,0,1,0,0,1,0,1 (0xA5, contiguous `sin_valid`), parity bit 0 -> `load_en` high for one cycle, `dout`=8'hA5, `busy` low afterwards, `frame_err` never asserted.
- **Parity error:** the same 0xA5 frame with parity bit 1 -> `frame_err` pulses once, no `load_en`, `dout` stays at its previous value (8'h00 after reset).
- **Gapped bits:** frame 0x3C with `sin_valid` low for 1–3 cycles between bits, parity bit 0 -> `busy` stays high across the gaps, `dout`=8'h3C, one `load_en`.
- **Abort and restart:** `start`, 3 data bits, `start` again, then 0xFF with parity bit 0 -> one `frame_err` pulse right after the second `start`, then `load_en` with `dout`=8'hFF. Exactly one `load_en` in total.
- **Reset mid-frame:** assert `rstn` after 5 bits -> all outputs 0 immediately. After release, frame 0x81 with parity bit 0 -> `dout`=8'h81.
- **Small width:** `Size`=4, frame 1,0,1,1 (4'hB), parity bit 1 -> `dout`=4'hB with one `load_en`. A `start` in the LOAD cycle begins the next frame with no idle cycle.
